hazard_tracker: RTL and testbench

- Stage-tracking hazard unit for the 5-stage pipelined RV32I core. It sits alongside the pipeline registers and is the producer side of the forwarding interface.
- Keeps its own shadow copy of the destination tag for each in-flight instruction (EX, MEM, WB). It drives the rd/reg_write tags that the forwarding mux selector consumes.
- Detects hazards that forwarding cannot cover (load-use, ecall on x17) and generates stall/bubble controls plus a stall watchdog.

---
 rtl/hazard_tracker.sv | 115 +++++++++++
 tb/tb_hazard_tracker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
// rtl/hazard_tracker.sv - stage-tracking hazard unit: load-use/ecall stalls, forwarding tags, stall watchdog
// Optional perf counters (stall_count, bubble_count) enabled by HAZARD_PERF_CNT_EN.
module hazard_tracker #(
  parameter int          MAX_STALL = 4,
  parameter logic [4:0]  ECALL_REG = 5'd17
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic        use_rs1_ID,
  input  logic        use_rs2_ID,
  input  logic [4:0]  rd_ID,
  input  logic        reg_write_ID,
  input  logic        mem_read_ID,
  input  logic        is_ecall_ID,
  input  logic        flush,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic [4:0]  rd_EX_MEM,
  output logic        reg_write_EX_MEM,
  output logic [4:0]  rd_MEM_WB,
  output logic        reg_write_MEM_WB,
  output logic        hazard_error
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_count,
  output logic [31:0] bubble_count
`endif
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } entry_t;

  localparam int              CW      = $clog2(MAX_STALL + 2);
  localparam logic [CW-1:0]   CNT_SAT = CW'(MAX_STALL + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_STALL);

  entry_t        ex_q, mem_q, wb_q;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic          ex_writer, mem_writer, wb_writer;
  logic          load_use, ecall_haz, stall;

  // x0 is hardwired zero, so an entry targeting it never produces data anyone waits for
  assign ex_writer  = ex_q.valid  & ex_q.reg_write  & (ex_q.rd  != 5'd0);
  assign mem_writer = mem_q.valid & mem_q.reg_write & (mem_q.rd != 5'd0);
  assign wb_writer  = wb_q.valid  & wb_q.reg_write  & (wb_q.rd  != 5'd0);

  assign load_use  = ex_writer & ex_q.mem_read &
                     ((use_rs1_ID & (rs1_ID == ex_q.rd)) | (use_rs2_ID & (rs2_ID == ex_q.rd)));
  assign ecall_haz = is_ecall_ID &
                     ((ex_writer & (ex_q.rd == ECALL_REG)) | (mem_writer & (mem_q.rd == ECALL_REG)));
  assign stall     = (load_use | ecall_haz) & ~flush;

  assign pc_write     = ~stall;
  assign if_id_write  = ~stall;
  assign id_ex_bubble = stall | flush;

  assign rd_EX_MEM        = mem_q.rd;
  assign reg_write_EX_MEM = mem_writer;
  assign rd_MEM_WB        = wb_q.rd;
  assign reg_write_MEM_WB = wb_writer;

  always_comb begin
    stall_cnt_d = '0;
    if (stall) begin
      stall_cnt_d = (stall_cnt_q == CNT_SAT) ? CNT_SAT : stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      stall_cnt_q  <= '0;
      hazard_error <= 1'b0;
    end else begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (id_ex_bubble) begin
        ex_q <= '0;
      end else begin
        ex_q <= '{valid: 1'b1, rd: rd_ID, reg_write: reg_write_ID, mem_read: mem_read_ID};
      end
      stall_cnt_q <= stall_cnt_d;
      // Flag on the same edge the count crosses the limit; sticky until reset
      if (stall_cnt_d > CNT_MAX) begin
        hazard_error <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (stall && (stall_count != 32'hFFFF_FFFF)) begin
        stall_count <= stall_count + 32'd1;
      end
      if (id_ex_bubble && (bubble_count != 32'hFFFF_FFFF)) begin
        bubble_count <= bubble_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// tb/tb_hazard_tracker.sv - self-checking bench for hazard_tracker
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] rs1_ID, rs2_ID, rd_ID;
  logic       use_rs1_ID, use_rs2_ID, reg_write_ID, mem_read_ID, is_ecall_ID, flush;

  logic       pc_write, if_id_write, id_ex_bubble;
  logic [4:0] rd_EX_MEM, rd_MEM_WB;
  logic       reg_write_EX_MEM, reg_write_MEM_WB, hazard_error;

  logic       w_pc_write, w_if_id_write, w_id_ex_bubble;
  logic [4:0] w_rd_EX_MEM, w_rd_MEM_WB;
  logic       w_reg_write_EX_MEM, w_reg_write_MEM_WB, w_hazard_error;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count, bubble_count, w_stall_count, w_bubble_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_tracker dut (
    .clk(clk), .reset_n(reset_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
    .rd_ID(rd_ID), .reg_write_ID(reg_write_ID), .mem_read_ID(mem_read_ID),
    .is_ecall_ID(is_ecall_ID), .flush(flush),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .rd_EX_MEM(rd_EX_MEM), .reg_write_EX_MEM(reg_write_EX_MEM),
    .rd_MEM_WB(rd_MEM_WB), .reg_write_MEM_WB(reg_write_MEM_WB),
    .hazard_error(hazard_error)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(stall_count), .bubble_count(bubble_count)
`endif
  );

  // Tight watchdog instance so the longest reachable stall run (2) trips it
  hazard_tracker #(.MAX_STALL(1)) dut_wd (
    .clk(clk), .reset_n(reset_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
    .rd_ID(rd_ID), .reg_write_ID(reg_write_ID), .mem_read_ID(mem_read_ID),
    .is_ecall_ID(is_ecall_ID), .flush(flush),
    .pc_write(w_pc_write), .if_id_write(w_if_id_write), .id_ex_bubble(w_id_ex_bubble),
    .rd_EX_MEM(w_rd_EX_MEM), .reg_write_EX_MEM(w_reg_write_EX_MEM),
    .rd_MEM_WB(w_rd_MEM_WB), .reg_write_MEM_WB(w_reg_write_MEM_WB),
    .hazard_error(w_hazard_error)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(w_stall_count), .bubble_count(w_bubble_count)
`endif
  );

  typedef struct {
    logic       pw;
    logic       bub;
    logic [4:0] rdm;
    logic       rwm;
    logic [4:0] rdw;
    logic       rww;
  } exp_t;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       rw, mr, ec, fl;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[17];

  function automatic vec_t mk(logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic [4:0] rd, logic rw, logic mr, logic ec, logic fl,
                              logic pw, logic bub, logic [4:0] rdm, logic rwm,
                              logic [4:0] rdw, logic rww);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.rd = rd; v.rw = rw; v.mr = mr; v.ec = ec; v.fl = fl;
    v.e.pw = pw; v.e.bub = bub; v.e.rdm = rdm; v.e.rwm = rwm; v.e.rdw = rdw; v.e.rww = rww;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                       logic [4:0] rd, logic rw, logic mr, logic ec, logic fl);
    rs1_ID = rs1; rs2_ID = rs2; use_rs1_ID = u1; use_rs2_ID = u2;
    rd_ID = rd; reg_write_ID = rw; mem_read_ID = mr; is_ecall_ID = ec; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("reset pc_write", pc_write, 1);
    chk("reset if_id_write", if_id_write, 1);
    chk("reset id_ex_bubble", id_ex_bubble, 0);
    chk("reset rd_EX_MEM", rd_EX_MEM, 0);
    chk("reset reg_write_EX_MEM", reg_write_EX_MEM, 0);
    chk("reset rd_MEM_WB", rd_MEM_WB, 0);
    chk("reset reg_write_MEM_WB", reg_write_MEM_WB, 0);
    chk("reset hazard_error", hazard_error, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("reset stall_count", stall_count, 0);
    chk("reset bubble_count", bubble_count, 0);
`endif
    step();
    reset_n = 1'b1;

    //           rs1 rs2 u1 u2 rd rw mr ec fl | pw bub rdm rwm rdw rww
    tbl[0]  = mk(0, 0, 0, 0, 5,  1, 1, 0, 0,  1, 0, 0,  0, 0,  0); // lw x5
    tbl[1]  = mk(5, 0, 1, 0, 6,  1, 0, 0, 0,  0, 1, 0,  0, 0,  0); // add uses x5: stall
    tbl[2]  = mk(5, 0, 1, 0, 6,  1, 0, 0, 0,  1, 0, 5,  1, 0,  0); // released
    tbl[3]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 5,  1);
    tbl[4]  = mk(0, 0, 0, 0, 0,  1, 1, 0, 0,  1, 0, 6,  1, 0,  0); // lw x0
    tbl[5]  = mk(0, 0, 1, 0, 7,  1, 0, 0, 0,  1, 0, 0,  0, 6,  1); // no stall on x0
    tbl[6]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0, 0,  0); // lw x0 not a writer
    tbl[7]  = mk(0, 0, 0, 0, 17, 1, 0, 0, 0,  1, 0, 7,  1, 0,  0); // addi x17
    tbl[8]  = mk(0, 0, 0, 0, 0,  0, 0, 1, 0,  0, 1, 0,  0, 7,  1); // ecall, x17 in EX
    tbl[9]  = mk(0, 0, 0, 0, 0,  0, 0, 1, 0,  0, 1, 17, 1, 0,  0); // x17 in MEM
    tbl[10] = mk(0, 0, 0, 0, 0,  0, 0, 1, 0,  1, 0, 0,  0, 17, 1); // x17 in WB: go
    tbl[11] = mk(0, 0, 0, 0, 9,  1, 1, 0, 0,  1, 0, 0,  0, 0,  0); // lw x9
    tbl[12] = mk(0, 9, 0, 1, 10, 1, 0, 0, 1,  1, 1, 0,  0, 0,  0); // load-use + flush
    tbl[13] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 9,  1, 0,  0);
    tbl[14] = mk(0, 0, 0, 0, 3,  1, 1, 0, 0,  1, 0, 0,  0, 9,  1); // lw x3
    tbl[15] = mk(3, 3, 0, 0, 4,  1, 0, 0, 0,  1, 0, 0,  0, 0,  0); // x3 not used
    tbl[16] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 3,  1, 0,  0);

    for (int i = 0; i < 17; i++) begin
      exp_t e;
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
            tbl[i].rw, tbl[i].mr, tbl[i].ec, tbl[i].fl);
      sb.push_back(tbl[i].e);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d pc_write", i), pc_write, e.pw);
      chk($sformatf("v%0d if_id_write", i), if_id_write, e.pw);
      chk($sformatf("v%0d id_ex_bubble", i), id_ex_bubble, e.bub);
      chk($sformatf("v%0d rd_EX_MEM", i), rd_EX_MEM, e.rdm);
      chk($sformatf("v%0d reg_write_EX_MEM", i), reg_write_EX_MEM, e.rwm);
      chk($sformatf("v%0d rd_MEM_WB", i), rd_MEM_WB, e.rdw);
      chk($sformatf("v%0d reg_write_MEM_WB", i), reg_write_MEM_WB, e.rww);
      step();
    end

    chk("table hazard_error max4", hazard_error, 0);
    chk("table hazard_error max1", w_hazard_error, 1);
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_count", stall_count, 3);
    chk("bubble_count", bubble_count, 4);
`endif

    // Reset asserted in the middle of a load-use stall
    drive(0, 0, 0, 0, 5, 1, 1, 0, 0);
    step();
    drive(5, 0, 1, 0, 6, 1, 0, 0, 0);
    #1;
    chk("pre-reset stall pc_write", pc_write, 0);
    reset_n = 1'b0;
    #1;
    chk("midstall reset pc_write", pc_write, 1);
    chk("midstall reset id_ex_bubble", id_ex_bubble, 0);
    chk("midstall reset hazard_error max1", w_hazard_error, 0);
    step();
    reset_n = 1'b1;
    #1;
    chk("post-release pc_write", pc_write, 1);
    step();

    // Watchdog on the MAX_STALL=1 instance: trips on the second stall edge
    drive(0, 0, 0, 0, 17, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("wd stall0 pc_write", w_pc_write, 0);
    chk("wd stall0 hazard_error", w_hazard_error, 0);
    step();
    chk("wd stall1 pc_write", w_pc_write, 0);
    chk("wd edge1 hazard_error", w_hazard_error, 0);
    step();
    chk("wd edge2 pc_write", w_pc_write, 1);
    chk("wd edge2 hazard_error", w_hazard_error, 1);
    chk("wd edge2 hazard_error max4", hazard_error, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("wd sticky hazard_error", w_hazard_error, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("wd async clear hazard_error", w_hazard_error, 0);
    step();
    reset_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
